fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 154 +++++++++++++++
 tb/tb_fetch_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC owner, memory read request, instruction register
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   mem_req_valid/ready/addr       fetch request channel (address is the current PC)
//   mem_rsp_valid/data/err         read response (single-cycle pulse, err qualified by valid)
//   redirect_valid/redirect_pc     branch/jump target load (single-cycle pulse)
//   inst_valid/ready/data/pc/fault instruction register toward decode

module fetch_unit #(
  parameter int unsigned       XLEN         = 32,
  parameter int unsigned       ILEN         = 32,
  parameter logic [XLEN-1:0]   RESET_VECTOR = 'h3000,
  parameter int unsigned       PC_STEP      = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [ILEN-1:0] mem_rsp_data,
  input  logic            mem_rsp_err,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_fault
);

  localparam logic [XLEN-1:0] PC_MASK = XLEN'(PC_STEP - 1);
  localparam logic [XLEN-1:0] PC_INC  = XLEN'(PC_STEP);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic [ILEN-1:0] inst_data_q, inst_data_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic            inst_fault_q, inst_fault_d;

  logic take_redirect;
  logic misaligned;
  logic accept;
  logic outstanding;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    inst_data_d  = inst_data_q;
    inst_pc_d    = inst_pc_q;
    inst_fault_d = inst_fault_q;

    take_redirect = redirect_valid && (state_q != S_IDLE);
    misaligned    = (redirect_pc & PC_MASK) != '0;
    accept        = (state_q == S_REQ) && mem_req_ready;
    // A read is still in flight after this edge if it is accepted now, or if
    // we are waiting and its response has not shown up yet.
    outstanding   = accept || ((state_q == S_WAIT) && !mem_rsp_valid);

    // Outside WAIT a response can only belong to an abandoned request.
    if (mem_rsp_valid && (state_q != S_WAIT)) begin
      drop_d = 1'b0;
    end

    if (take_redirect) begin
      pc_d = redirect_pc;
      if (outstanding) begin
        drop_d = 1'b1;
      end else if (state_q == S_WAIT) begin
        drop_d = 1'b0;  // the response arriving now is the one being discarded
      end
      if (misaligned) begin
        // No fetch: the bad target itself is handed to decode as a fault entry.
        inst_data_d  = '0;
        inst_pc_d    = redirect_pc;
        inst_fault_d = 1'b1;
        state_d      = S_HOLD;
      end else if (outstanding) begin
        state_d = S_WAIT;
      end else begin
        state_d = S_REQ;
      end
    end else begin
      case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ: begin
          if (accept) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (mem_rsp_valid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = S_REQ;
            end else begin
              inst_data_d  = mem_rsp_data;
              inst_pc_d    = pc_q;
              inst_fault_d = mem_rsp_err;
              state_d      = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (inst_ready) begin
            if (inst_fault_q) begin
              state_d = S_FAULT;
            end else begin
              pc_d    = pc_q + PC_INC;
              state_d = S_REQ;
            end
          end
        end
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_VECTOR;
      drop_q       <= 1'b0;
      inst_data_q  <= '0;
      inst_pc_q    <= '0;
      inst_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_q       <= drop_d;
      inst_data_q  <= inst_data_d;
      inst_pc_q    <= inst_pc_d;
      inst_fault_q <= inst_fault_d;
    end
  end

  assign mem_req_valid = (state_q == S_REQ);
  assign mem_req_addr  = pc_q;
  assign inst_valid    = (state_q == S_HOLD);
  assign inst_data     = inst_data_q;
  assign inst_pc       = inst_pc_q;
  assign inst_fault    = inst_fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized scoreboard bench for fetch_unit

module tb_fetch_unit;

  localparam logic [31:0] RV = 32'h3000;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid, mem_rsp_err;
  logic [31:0] mem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_ready, inst_fault;
  logic [31:0] inst_data, inst_pc;

  logic        w_req_valid, w_rsp_valid, w_inst_valid, w_inst_fault;
  logic [15:0] w_req_addr, w_inst_pc;
  logic [31:0] w_inst_data;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
    .inst_pc(inst_pc), .inst_fault(inst_fault)
  );

  fetch_unit #(.XLEN(16), .ILEN(32), .RESET_VECTOR(16'hFFFC), .PC_STEP(4)) dut_w (
    .clk(clk), .rst(rst),
    .mem_req_valid(w_req_valid), .mem_req_ready(1'b1), .mem_req_addr(w_req_addr),
    .mem_rsp_valid(w_rsp_valid), .mem_rsp_data(32'h0), .mem_rsp_err(1'b0),
    .redirect_valid(1'b0), .redirect_pc(16'h0),
    .inst_valid(w_inst_valid), .inst_ready(1'b1), .inst_data(w_inst_data),
    .inst_pc(w_inst_pc), .inst_fault(w_inst_fault)
  );

  int checks = 0;
  int failures = 0;
  int hs_count = 0;
  int since = 0;
  bit fast = 1'b1;
  bit pend = 1'b0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic        fault;
    logic        fetchable;
  } ent_t;

  ent_t        exp_q[$];
  bit          front_fetched = 1'b0;
  logic [15:0] w_addrs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Memory image: fixed word at the reset vector, hashed words elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h3000) return 32'h0000_0013;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    logic [7:0] w;
    w = a[9:2];
    return (w % 8'd13) == 8'd2;
  endfunction

  function automatic ent_t mk(input logic [31:0] a);
    ent_t e;
    e.pc = a;
    if (a[1:0] != 2'b00) begin
      e.data = 32'h0; e.fault = 1'b1; e.fetchable = 1'b0;
    end else begin
      e.data = mem_word(a); e.fault = mem_err(a); e.fetchable = 1'b1;
    end
    return e;
  endfunction

  task automatic expect_only(input logic [31:0] a);
    exp_q.delete();
    exp_q.push_back(mk(a));
    front_fetched = 1'b0;
  endtask

  // Memory responder: at most one outstanding read, random latency.
  initial begin
    bit          acc;
    logic [31:0] acc_addr, pend_addr;
    int          cnt;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_err = 1'b0;
    cnt = 0; pend_addr = '0;
    forever begin
      @(negedge clk);
      acc = mem_req_valid && mem_req_ready && !rst;
      acc_addr = mem_req_addr;
      @(posedge clk); #1;
      mem_rsp_valid = 1'b0;
      if (acc) begin
        pend = 1'b1; pend_addr = acc_addr;
        cnt = fast ? 0 : int'($urandom_range(0, 3));
      end
      if (pend) begin
        if (cnt == 0) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = mem_word(pend_addr);
          mem_rsp_err   = mem_err(pend_addr);
          pend = 1'b0;
        end else begin
          cnt--;
        end
      end
      mem_req_ready = !pend && (fast || $urandom_range(0, 3) != 0);
    end
  end

  // Narrow instance: always-ready memory, one-cycle response.
  initial begin
    bit acc16;
    w_rsp_valid = 1'b0;
    forever begin
      @(negedge clk);
      acc16 = w_req_valid && !rst;
      if (acc16 && w_addrs.size() < 2) w_addrs.push_back(w_req_addr);
      @(posedge clk); #1;
      w_rsp_valid = acc16;
    end
  end

  // Monitor: compares fetch addresses, delivered entries and hold stability.
  initial begin
    ent_t        e;
    bit          prev_hold;
    logic [31:0] pd, pp;
    logic        pf;
    prev_hold = 1'b0; pd = '0; pp = '0; pf = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_hold = 1'b0;
        continue;
      end
      if (mem_req_valid && mem_req_ready && !redirect_valid) begin
        if (exp_q.size() == 0 || !exp_q[0].fetchable || front_fetched) begin
          chk("unexpected_fetch", {32'h0, mem_req_addr}, 64'hFFFF_FFFF);
        end else begin
          chk("fetch_addr", {32'h0, mem_req_addr}, {32'h0, exp_q[0].pc});
          front_fetched = 1'b1;
        end
      end
      if (prev_hold) begin
        chk("hold_stable", {inst_valid, inst_fault, inst_pc, inst_data[29:0]},
            {1'b1, pf, pp, pd[29:0]});
      end
      prev_hold = inst_valid && !inst_ready && !redirect_valid;
      pd = inst_data; pp = inst_pc; pf = inst_fault;
      if (inst_valid && inst_ready) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          chk("unexpected_inst", {32'h0, inst_pc}, 64'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          front_fetched = 1'b0;
          chk("inst_entry", {inst_fault, inst_pc, inst_data[30:0]},
              {e.fault, e.pc, e.data[30:0]});
          chk("inst_data_msb", {63'h0, inst_data[31]}, {63'h0, e.data[31]});
          if (!e.fault) exp_q.push_back(mk(e.pc + 32'd4));
        end
      end
    end
  end

  task automatic step(input bit rdy);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    inst_ready = rdy;
    since++;
  endtask

  task automatic redir(input logic [31:0] t);
    @(posedge clk); #1;
    inst_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = t;
    expect_only(t);
    since++;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    redirect_valid = 1'b0;
    inst_ready = 1'b0;
    #1;
    chk("rst_async_outputs", {mem_req_valid, inst_valid, inst_fault, inst_pc, 29'h0},
        {3'b000, 32'h0, 29'h0});
    chk("rst_async_data", {32'h0, inst_data}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    expect_only(RV);
    since = 0;
  endtask

  initial begin
    logic [31:0] t;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {mem_req_valid, inst_valid, inst_fault, inst_pc, mem_req_addr[28:0]},
        {3'b000, 32'h0, RV[28:0]});
    chk("reset_data", {32'h0, inst_data}, 64'h0);
    rst = 1'b0;
    inst_ready = 1'b1;
    expect_only(RV);
    @(negedge clk);
    chk("idle_no_req", {63'h0, mem_req_valid}, 64'h0);
    @(negedge clk);
    chk("first_req", {31'h0, mem_req_valid, mem_req_addr}, {31'h0, 1'b1, RV});
    @(negedge clk);
    chk("no_early_inst", {63'h0, inst_valid}, 64'h0);
    @(negedge clk);
    chk("first_inst", {inst_valid, inst_pc, inst_data[30:0]}, {1'b1, RV, 31'h13});

    // 3004 then 3008 (bus error) and the unit parks in FAULT.
    repeat (20) step(1'b1);
    chk("fault_after_3", {32'h0, hs_count}, 64'd3);
    chk("fault_queue_empty", {32'h0, exp_q.size()}, 64'd0);
    redir(32'h3100);
    repeat (10) step(1'b1);
    redir(32'h4002);
    repeat (5) step(1'b0);
    step(1'b1);
    repeat (3) step(1'b1);
    redir(32'h4000);
    repeat (5) step(1'b1);

    fast = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (pend && since >= 2 && $urandom_range(0, 149) == 0) begin
        do_reset();
      end else if (since >= 2 && $urandom_range(0, 19) == 0) begin
        t = 32'h3000 + (32'($urandom_range(0, 1023)) << 2);
        if ($urandom_range(0, 4) == 0) t = t + 32'($urandom_range(1, 3));
        redir(t);
      end else begin
        step($urandom_range(0, 9) < 7);
      end
    end
    step(1'b0);
    @(negedge clk);

    chk("progress", {63'h0, hs_count > 200}, 64'h1);
    chk("narrow_fetches", {32'h0, w_addrs.size()}, 64'd2);
    if (w_addrs.size() == 2) begin
      chk("narrow_first", {48'h0, w_addrs[0]}, 64'hFFFC);
      chk("narrow_wrap", {48'h0, w_addrs[1]}, 64'h0000);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
